// File: rtl/pixel_frame_sequencer_if.sv
// Bus bundle between the pixel frame sequencer and its surroundings:
// frame control/config, input frame RAM read port, pixel-op datapath
// port and the result sink handshake.
//   master : the sequencer (drives status, RAM read, datapath operands, sink)
//   slave  : loader / RAM / datapath / sink side
interface pixel_frame_sequencer_if #(
  parameter int unsigned ADDR_W = 17
);
  // frame control and config
  logic              start;
  logic [1:0]        cfg_select;
  logic [7:0]        cfg_value;
  logic [7:0]        cfg_thresh;
  logic              busy;
  logic              done;
  // input frame RAM
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  // pixel-op datapath
  logic [1:0]        op_select;
  logic [7:0]        op_value;
  logic [7:0]        op_threshold;
  logic [7:0]        op_in_byte;
  logic [7:0]        op_out_byte;
  // result sink
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    input  start, cfg_select, cfg_value, cfg_thresh, rd_data, op_out_byte, wr_ready,
    output busy, done, rd_en, rd_addr, op_select, op_value, op_threshold, op_in_byte,
           wr_valid, wr_addr, wr_data
  );

  modport slave (
    output start, cfg_select, cfg_value, cfg_thresh, rd_data, op_out_byte, wr_ready,
    input  busy, done, rd_en, rd_addr, op_select, op_value, op_threshold, op_in_byte,
           wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/pixel_frame_sequencer.sv
// Frame-level controller for the 8-bit pixel-operation datapath. On start it
// latches the op config, streams NPIX pixels from the input frame RAM through
// the (non-stallable) datapath and hands results to the sink through a small
// credit-limited FIFO that absorbs sink back-pressure.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : pixel_frame_sequencer_if.master
//              start/cfg_* in, busy/done out; rd_en/rd_addr out, rd_data in;
//              op_* out, op_out_byte in; wr_valid/wr_addr/wr_data out, wr_ready in
module pixel_frame_sequencer #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned NPIX   = 98304,
  parameter int unsigned OP_LAT = 1,
  parameter int unsigned FIFO_D = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pixel_frame_sequencer_if.master bus
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_D);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned CRED_W = PTR_W + 2;
  localparam int unsigned VLD_W  = OP_LAT + 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               busy_q, done_q;
  logic [1:0]         op_select_q;
  logic [7:0]         op_value_q, op_threshold_q, op_in_byte_q;
  logic [CNT_W-1:0]   issue_cnt_q, wr_cnt_q;
  logic [VLD_W-1:0]   vld_q;
  logic [CRED_W-1:0]  inflight_q;
  logic [7:0]         fifo_mem [FIFO_D];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]  fifo_cnt_q;
  logic               rd_en_c, credit_ok, push, pop, fifo_nempty, accept_start;

  assign fifo_nempty  = (fifo_cnt_q != '0);
  assign pop          = fifo_nempty && bus.wr_ready;
  assign push         = vld_q[VLD_W-1];
  assign accept_start = (state_q == S_IDLE) && bus.start;

  // A slot freed by this cycle's pop is reusable immediately, which keeps the
  // read stream at one pixel per clock while the sink is ready.
  assign credit_ok = (inflight_q + CRED_W'(fifo_cnt_q)) < (CRED_W'(FIFO_D) + CRED_W'(pop));

  // Next state and read issue
  always_comb begin
    state_d = state_q;
    rd_en_c = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN: begin
        rd_en_c = credit_ok;
        if (credit_ok && (issue_cnt_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: if (pop && (wr_cnt_q == LAST_IDX)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Config latch and read/write counters; counters hold at the last index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_select_q    <= '0;
      op_value_q     <= '0;
      op_threshold_q <= '0;
      issue_cnt_q    <= '0;
      wr_cnt_q       <= '0;
    end else if (accept_start) begin
      op_select_q    <= bus.cfg_select;
      op_value_q     <= bus.cfg_value;
      op_threshold_q <= bus.cfg_thresh;
      issue_cnt_q    <= '0;
      wr_cnt_q       <= '0;
    end else begin
      if (rd_en_c && (issue_cnt_q != LAST_IDX)) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      if (pop && (wr_cnt_q != LAST_IDX))        wr_cnt_q    <= wr_cnt_q + CNT_W'(1);
    end
  end

  // Datapath feed and valid delay line matching RAM + input reg + OP_LAT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_in_byte_q <= '0;
      vld_q        <= '0;
      inflight_q   <= '0;
    end else begin
      op_in_byte_q <= bus.rd_data;
      vld_q        <= {vld_q[VLD_W-2:0], rd_en_c};
      inflight_q   <= inflight_q + CRED_W'(rd_en_c) - CRED_W'(push);
    end
  end

  // Result FIFO control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_q + FCNT_W'(push) - FCNT_W'(pop);
    end
  end

  // Result FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.op_out_byte;
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.rd_en        = rd_en_c;
  assign bus.rd_addr      = issue_cnt_q[ADDR_W-1:0];
  assign bus.op_select    = op_select_q;
  assign bus.op_value     = op_value_q;
  assign bus.op_threshold = op_threshold_q;
  assign bus.op_in_byte   = op_in_byte_q;
  assign bus.wr_valid     = fifo_nempty;
  assign bus.wr_addr      = wr_cnt_q[ADDR_W-1:0];
  assign bus.wr_data      = fifo_nempty ? fifo_mem[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Bench for pixel_frame_sequencer: an 8-pixel instance and a 1-pixel
// instance, each with a RAM model, a 1-clock datapath model and a scoreboard
// of expected (addr, data) pairs filled at start and drained on sink accepts.
module tb_pixel_frame_sequencer;
  localparam int unsigned AW  = 4;
  localparam int unsigned NA  = 8;
  localparam int unsigned LAT = 1;
  localparam int unsigned FD  = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_frame_sequencer_if #(.ADDR_W(AW)) a_if();
  pixel_frame_sequencer_if #(.ADDR_W(AW)) b_if();

  pixel_frame_sequencer #(.ADDR_W(AW), .NPIX(NA), .OP_LAT(LAT), .FIFO_D(FD)) u_dut_a (
    .clk(clk), .rst(rst), .bus(a_if.master)
  );
  pixel_frame_sequencer #(.ADDR_W(AW), .NPIX(1), .OP_LAT(LAT), .FIFO_D(FD)) u_dut_b (
    .clk(clk), .rst(rst), .bus(b_if.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference pixel operation (saturating add/sub, threshold, invert)
  function automatic logic [7:0] pix_op(input logic [1:0] s, input logic [7:0] v,
                                        input logic [7:0] t, input logic [7:0] p);
    logic [8:0] sum;
    sum = {1'b0, p} + {1'b0, v};
    case (s)
      2'b00:   return sum[8] ? 8'hFF : sum[7:0];
      2'b01:   return (p > v) ? (p - v) : 8'h00;
      2'b10:   return (p > t) ? 8'hFF : 8'h00;
      default: return ~p;
    endcase
  endfunction

  // RAM and datapath models
  logic [7:0] ram_a [NA];
  logic [7:0] ram_b;
  always @(posedge clk) if (a_if.rd_en) a_if.rd_data <= ram_a[a_if.rd_addr[2:0]];
  always @(posedge clk) if (b_if.rd_en) b_if.rd_data <= ram_b;
  always @(posedge clk)
    a_if.op_out_byte <= pix_op(a_if.op_select, a_if.op_value, a_if.op_threshold, a_if.op_in_byte);
  always @(posedge clk)
    b_if.op_out_byte <= pix_op(b_if.op_select, b_if.op_value, b_if.op_threshold, b_if.op_in_byte);

  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t qa[$];
  exp_t qb[$];

  // Monitor for instance A
  int a_iss = 0, a_acc = 0, a_done = 0, a_last_acc = 0, a_max_out = 0, a_next_rd = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      qa.delete();
      a_iss     = a_acc;
      a_next_rd = 0;
    end else begin
      if (a_if.rd_en) begin
        check_val("a_rd_addr", 32'(a_if.rd_addr), 32'(a_next_rd));
        a_next_rd = (a_next_rd + 1) % NA;
        a_iss++;
      end
      if (a_if.wr_valid && a_if.wr_ready) begin
        a_acc++;
        a_last_acc = cyc;
        if (qa.size() == 0) begin
          check_val("a_sb_nonempty", 32'(qa.size()), 32'd1);
        end else begin
          e = qa.pop_front();
          check_val("a_wr_addr", 32'(a_if.wr_addr), 32'(e.addr));
          check_val("a_wr_data", 32'(a_if.wr_data), 32'(e.data));
        end
      end
      if (a_iss - a_acc > a_max_out) a_max_out = a_iss - a_acc;
      if (a_if.done) begin
        a_done++;
        check_val("a_done_after_last", 32'(cyc - a_last_acc), 32'd1);
      end
    end
  end

  // Monitor for instance B
  int b_iss = 0, b_acc = 0, b_done = 0, b_last_acc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      qb.delete();
    end else begin
      if (b_if.rd_en) begin
        b_iss++;
        check_val("b_rd_addr", 32'(b_if.rd_addr), 32'd0);
      end
      if (b_if.wr_valid && b_if.wr_ready) begin
        b_acc++;
        b_last_acc = cyc;
        if (qb.size() == 0) begin
          check_val("b_sb_nonempty", 32'(qb.size()), 32'd1);
        end else begin
          e = qb.pop_front();
          check_val("b_wr_addr", 32'(b_if.wr_addr), 32'(e.addr));
          check_val("b_wr_data", 32'(b_if.wr_data), 32'(e.data));
        end
      end
      if (b_if.done) begin
        b_done++;
        check_val("b_done_after_last", 32'(cyc - b_last_acc), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [1:0] sel, input logic [7:0] v, input logic [7:0] t);
    for (int i = 0; i < NA; i++) qa.push_back(exp_t'{addr: AW'(i), data: pix_op(sel, v, t, ram_a[i])});
    a_if.cfg_select = sel;
    a_if.cfg_value  = v;
    a_if.cfg_thresh = t;
    a_if.start      = 1'b1;
    tick();
    a_if.start      = 1'b0;
  endtask

  task automatic start_b(input logic [1:0] sel, input logic [7:0] v, input logic [7:0] t);
    qb.push_back(exp_t'{addr: AW'(0), data: pix_op(sel, v, t, ram_b)});
    b_if.cfg_select = sel;
    b_if.cfg_value  = v;
    b_if.cfg_thresh = t;
    b_if.start      = 1'b1;
    tick();
    b_if.start      = 1'b0;
  endtask

  // Leaves the bench in the cycle where done is high
  task automatic wait_done_a(input string tag);
    int n = 0;
    while (!a_if.done && n < 300) begin tick(); n++; end
    check_val(tag, 32'(n < 300), 32'd1);
  endtask

  task automatic wait_done_b(input string tag);
    int n = 0;
    while (!b_if.done && n < 300) begin tick(); n++; end
    check_val(tag, 32'(n < 300), 32'd1);
  endtask

  task automatic wait_acc_a(input int target, input string tag);
    int n = 0;
    while (a_acc < target && n < 300) begin tick(); n++; end
    check_val(tag, 32'(n < 300), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    int n, c0, acc0, done0, iss0, stalled_rd;
    logic [7:0]    hold_d;
    logic [AW-1:0] hold_a;

    rst = 1'b1;
    a_if.start = 1'b0; a_if.cfg_select = '0; a_if.cfg_value = '0; a_if.cfg_thresh = '0; a_if.wr_ready = 1'b1;
    b_if.start = 1'b0; b_if.cfg_select = '0; b_if.cfg_value = '0; b_if.cfg_thresh = '0; b_if.wr_ready = 1'b1;
    ram_b = 8'h00;
    for (int i = 0; i < NA; i++) ram_a[i] = 8'(i);
    tick(); tick();

    // reset state
    check_val("rst_busy",     32'(a_if.busy), 32'd0);
    check_val("rst_done",     32'(a_if.done), 32'd0);
    check_val("rst_rd_en",    32'(a_if.rd_en), 32'd0);
    check_val("rst_wr_valid", 32'(a_if.wr_valid), 32'd0);
    check_val("rst_rd_addr",  32'(a_if.rd_addr), 32'd0);
    check_val("rst_wr_addr",  32'(a_if.wr_addr), 32'd0);
    check_val("rst_op_cfg",   32'({a_if.op_select, a_if.op_value, a_if.op_threshold, a_if.op_in_byte}), 32'd0);
    rst = 1'b0;
    tick();

    // 1: invert ramp, latency and back-to-back writes
    start_a(2'b11, 8'h00, 8'h00);
    check_val("t1_busy_after_start", 32'(a_if.busy), 32'd1);
    n = 0;
    while (!a_if.wr_valid && n < 50) begin tick(); n++; end
    check_val("t1_first_valid_latency", 32'(n + 1), 32'(1 + 3 + LAT));
    c0 = cyc;
    wait_done_a("t1_done_seen");
    check_val("t1_accept_span", 32'(a_last_acc - c0), 32'(NA - 1));
    check_val("t1_busy_in_done", 32'(a_if.busy), 32'd0);
    tick();

    // 2: saturating add then sub
    ram_a[0] = 8'h00; ram_a[1] = 8'hC3; ram_a[2] = 8'hC4; ram_a[3] = 8'hFF;
    ram_a[4] = 8'h10; ram_a[5] = 8'h3C; ram_a[6] = 8'h80; ram_a[7] = 8'h7F;
    start_a(2'b00, 8'h3C, 8'h00);
    wait_done_a("t2_add_done");
    tick();
    start_a(2'b01, 8'h3C, 8'h00);
    wait_done_a("t2_sub_done");
    tick();

    // 3: sink stall mid-frame
    for (int i = 0; i < NA; i++) ram_a[i] = 8'($urandom_range(0, 255));
    acc0 = a_acc;
    start_a(2'b00, 8'($urandom_range(0, 255)), 8'h00);
    wait_acc_a(acc0 + 2, "t3_reach_stall");
    a_if.wr_ready = 1'b0;
    tick();
    hold_d = a_if.wr_data;
    hold_a = a_if.wr_addr;
    stalled_rd = 0;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (i >= 10 && a_if.rd_en) stalled_rd++;
    end
    check_val("t3_rd_en_during_stall", 32'(stalled_rd), 32'd0);
    check_val("t3_wr_data_held", 32'(a_if.wr_data), 32'(hold_d));
    check_val("t3_wr_addr_held", 32'(a_if.wr_addr), 32'(hold_a));
    check_val("t3_wr_valid_held", 32'(a_if.wr_valid), 32'd1);
    a_if.wr_ready = 1'b1;
    wait_done_a("t3_done_seen");
    check_val("t3_accept_count", 32'(a_acc - acc0), 32'(NA));
    check_val("t3_sb_drained", 32'(qa.size()), 32'd0);
    check_val("t3_max_outstanding", 32'(a_max_out), 32'(FD));
    tick();

    // 4: start pulses in RUN and in DONE are ignored
    done0 = a_done;
    start_a(2'b11, 8'h00, 8'h00);
    tick(); tick();
    a_if.cfg_select = 2'b00; a_if.cfg_value = 8'h55; a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    check_val("t4_op_select_kept", 32'(a_if.op_select), 32'd3);
    wait_done_a("t4_done_seen");
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    tick();
    check_val("t4_idle_after_done_start", 32'({a_if.busy, a_if.rd_en}), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check_val("t4_single_done", 32'(a_done - done0), 32'd1);
    check_val("t4_sb_drained", 32'(qa.size()), 32'd0);

    // 5: reset mid-frame, then a clean frame
    done0 = a_done;
    start_a(2'b01, 8'h11, 8'h00);
    n = 0;
    while (!(a_if.rd_en && a_if.rd_addr == AW'(5)) && n < 50) begin tick(); n++; end
    check_val("t5_reach_pixel5", 32'(n < 50), 32'd1);
    rst = 1'b1;
    #1;
    check_val("t5_rst_outputs",
              32'({a_if.busy, a_if.done, a_if.rd_en, a_if.wr_valid, a_if.rd_addr, a_if.wr_addr}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_val("t5_no_done_on_abort", 32'(a_done - done0), 32'd0);
    acc0 = a_acc;
    start_a(2'b11, 8'h00, 8'h00);
    wait_done_a("t5_done_seen");
    check_val("t5_accept_count", 32'(a_acc - acc0), 32'(NA));
    tick();

    // 6: single-pixel frames, threshold either side
    iss0 = b_iss;
    acc0 = b_acc;
    ram_b = 8'hA1;
    start_b(2'b10, 8'h00, 8'hA0);
    wait_done_b("t6_a1_done");
    tick();
    ram_b = 8'hA0;
    start_b(2'b10, 8'h00, 8'hA0);
    wait_done_b("t6_a0_done");
    tick();
    check_val("t6_read_count", 32'(b_iss - iss0), 32'd2);
    check_val("t6_write_count", 32'(b_acc - acc0), 32'd2);
    check_val("t6_done_count", 32'(b_done), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
